// File: rtl/branch_predict_unit_if.sv
// Bundle between the pipeline and the branch predict unit.
//   Fetch lookup : if_pc -> pred_taken / pred_target (same cycle)
//   EX resolve   : ex_valid, ex_pc, ex_branch, ex_jump, ex_funct3, ex_opcode,
//                  ex_imm, ex_alu_result, ex_pred_taken, ex_pred_target
//   Feedback     : mispredict, redirect_pc (registered), branch_cnt,
//                  mispredict_cnt (performance counters)
// master = pipeline side, slave = predictor side.
interface branch_predict_unit_if #(
    parameter int PC_W   = 9,
    parameter int STAT_W = 16
);
    logic [PC_W-1:0]   if_pc;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;

    logic              ex_valid;
    logic [PC_W-1:0]   ex_pc;
    logic              ex_branch;
    logic              ex_jump;
    logic [2:0]        ex_funct3;
    logic [6:0]        ex_opcode;
    logic [31:0]       ex_imm;
    logic [31:0]       ex_alu_result;
    logic              ex_pred_taken;
    logic [PC_W-1:0]   ex_pred_target;

    logic              mispredict;
    logic [PC_W-1:0]   redirect_pc;
    logic [STAT_W-1:0] branch_cnt;
    logic [STAT_W-1:0] mispredict_cnt;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_branch, ex_jump, ex_funct3, ex_opcode,
               ex_imm, ex_alu_result, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc,
               branch_cnt, mispredict_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_branch, ex_jump, ex_funct3, ex_opcode,
               ex_imm, ex_alu_result, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc,
               branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch predictor / resolver.
// Direct-mapped BTB with 2-bit saturating direction counters. Fetch gets a
// same-cycle predicted next PC; EX resolves branches/jumps, trains the BTB and
// raises a registered one-cycle mispredict with the correct redirect PC.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset
//   bus   - branch_predict_unit_if.slave (lookup, resolve, feedback, counters)
module branch_predict_unit #(
    parameter int         PC_W      = 9,
    parameter int         BTB_DEPTH = 16,
    parameter logic [1:0] CNT_INIT  = 2'b10,
    parameter int         STAT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_predict_unit_if.slave bus
);
    localparam int         IDX_W   = $clog2(BTB_DEPTH);
    localparam int         TAG_W   = PC_W - IDX_W - 2;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // BTB storage, one slot per index
    logic [BTB_DEPTH-1:0]             ent_valid;
    logic [BTB_DEPTH-1:0]             ent_jal;
    logic [BTB_DEPTH-1:0][TAG_W-1:0]  ent_tag;
    logic [BTB_DEPTH-1:0][1:0]        ent_ctr;
    logic [BTB_DEPTH-1:0][PC_W-1:0]   ent_tgt;

    // ---------------- fetch lookup ----------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx = bus.if_pc[IDX_W+1:2];
    assign lk_tag = bus.if_pc[PC_W-1:IDX_W+2];
    assign lk_hit = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);

    // JAL entries predict taken regardless of the counter
    assign bus.pred_taken  = lk_hit && (ent_ctr[lk_idx][1] || ent_jal[lk_idx]);
    assign bus.pred_target = bus.pred_taken ? ent_tgt[lk_idx] : bus.if_pc + PC_W'(4);

    // ---------------- EX resolution ----------------
    logic             is_jal_op, is_jalr_op, br_taken, act_taken, resolve, mispred;
    logic [31:0]      rel_tgt32, jalr_tgt32;
    logic [PC_W-1:0]  act_target, ex_pc_p4;
    logic             unused_bits;

    assign is_jal_op  = (bus.ex_opcode == OP_JAL);
    assign is_jalr_op = (bus.ex_opcode == OP_JALR);
    assign rel_tgt32  = 32'(bus.ex_pc) + bus.ex_imm;
    assign jalr_tgt32 = {bus.ex_alu_result[31:1], 1'b0};
    assign ex_pc_p4   = bus.ex_pc + PC_W'(4);
    // upper target bits are dropped by the truncation to PC_W
    assign unused_bits = ^{rel_tgt32, jalr_tgt32};

    // ALU bit 0 holds the raw compare (eq for beq/bne, lt for blt/bge)
    always_comb begin
        br_taken = 1'b0;
        case (bus.ex_funct3)
            3'b000, 3'b100: br_taken = bus.ex_alu_result[0];
            3'b001, 3'b101: br_taken = ~bus.ex_alu_result[0];
            default:        br_taken = 1'b0;
        endcase
    end

    assign act_taken  = bus.ex_jump ? (is_jal_op | is_jalr_op) : br_taken;
    assign act_target = (bus.ex_jump && is_jalr_op) ? jalr_tgt32[PC_W-1:0]
                                                    : rel_tgt32[PC_W-1:0];
    assign resolve    = bus.ex_valid && (bus.ex_branch || bus.ex_jump);
    assign mispred    = resolve &&
                        ((act_taken != bus.ex_pred_taken) ||
                         (act_taken && bus.ex_pred_taken &&
                          (act_target != bus.ex_pred_target)));

    // ---------------- BTB training ----------------
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit, alloc, bump;
    logic [1:0]       cur_ctr, ctr_nxt;

    assign up_idx  = bus.ex_pc[IDX_W+1:2];
    assign up_tag  = bus.ex_pc[PC_W-1:IDX_W+2];
    assign up_hit  = ent_valid[up_idx] && (ent_tag[up_idx] == up_tag);
    assign cur_ctr = ent_ctr[up_idx];

    // JALR never trains; a taken branch miss or any JAL (re)allocates
    assign alloc = resolve && (bus.ex_jump ? is_jal_op : (!up_hit && act_taken));
    assign bump  = resolve && !bus.ex_jump && up_hit;

    always_comb begin
        ctr_nxt = cur_ctr;
        if (alloc)
            ctr_nxt = bus.ex_jump ? 2'b11 : CNT_INIT;
        else if (act_taken)
            ctr_nxt = (cur_ctr == 2'b11) ? cur_ctr : cur_ctr + 2'd1;
        else
            ctr_nxt = (cur_ctr == 2'b00) ? cur_ctr : cur_ctr - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_valid <= '0;
            ent_ctr   <= '0;
        end else begin
            if (alloc)        ent_valid[up_idx] <= 1'b1;
            if (alloc | bump) ent_ctr[up_idx]   <= ctr_nxt;
        end
    end

    // payload fields carry no reset; valid qualifies them
    always_ff @(posedge clk) begin
        if (rst_n && alloc) begin
            ent_tag[up_idx] <= up_tag;
            ent_jal[up_idx] <= bus.ex_jump;
        end
        if (rst_n && (alloc || (bump && act_taken)))
            ent_tgt[up_idx] <= act_target;
    end

    // ---------------- feedback and counters ----------------
    logic              mispredict_q;
    logic [PC_W-1:0]   redirect_q;
    logic [STAT_W-1:0] branch_cnt_q, mispredict_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mispredict_q     <= 1'b0;
            redirect_q       <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            mispredict_q <= mispred;
            if (mispred)
                redirect_q <= act_taken ? act_target : ex_pc_p4;
            if (resolve && (branch_cnt_q != '1))
                branch_cnt_q <= branch_cnt_q + STAT_W'(1);
            if (mispred && (mispredict_cnt_q != '1))
                mispredict_cnt_q <= mispredict_cnt_q + STAT_W'(1);
        end
    end

    assign bus.mispredict     = mispredict_q;
    assign bus.redirect_pc    = redirect_q;
    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: driver issues one stimulus per
// cycle, a behavioural model pushes expected lookup and registered results
// into queues, and a monitor on the falling edge pops and compares.
module tb_branch_predict_unit;
    localparam int PC_W  = 9;
    localparam int DEPTH = 16;
    localparam int IDX_W = 4;
    localparam int STAT_W = 16;
    localparam int MASK  = (1 << PC_W) - 1;
    localparam int SMAX  = (1 << STAT_W) - 1;
    localparam int JAL   = 'h6F;
    localparam int JALR  = 'h67;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_predict_unit_if #(.PC_W(PC_W), .STAT_W(STAT_W)) bus ();

    branch_predict_unit #(
        .PC_W(PC_W), .BTB_DEPTH(DEPTH), .CNT_INIT(2'b10), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // ---------------- reference model ----------------
    typedef struct { bit v; int owner; int ctr; int tgt; bit jal; } ment_t;
    typedef struct { bit t; int tgt; } pexp_t;
    typedef struct { bit mis; int rpc; int bc; int mc; } rexp_t;

    ment_t m [DEPTH];
    int    e_rpc, e_bc, e_mc;
    pexp_t pred_q[$];
    rexp_t reg_q[$];
    int    checks = 0;
    int    errors = 0;

    // a slot belongs to the PC block that last claimed it
    function automatic int slot_of(int pc);
        return (pc / 4) % DEPTH;
    endfunction

    function automatic int block_of(int pc);
        return pc / (4 * DEPTH);
    endfunction

    function automatic pexp_t lookup(int pc);
        pexp_t p;
        ment_t e = m[slot_of(pc)];
        bit    hit = e.v && (e.owner == block_of(pc));
        p.t   = hit && (e.ctr >= 2 || e.jal);
        p.tgt = p.t ? e.tgt : ((pc + 4) & MASK);
        return p;
    endfunction

    function automatic void model_step(bit rst, bit valid, int kind, int pc, int f3,
                                       int op, int imm, int alu, bit pt, int ptg);
        bit    taken, mis, hit;
        int    tgt, s;
        rexp_t r;
        mis = 0;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) m[i].v = 0;
            for (int i = 0; i < DEPTH; i++) m[i].ctr = 0;
            e_rpc = 0; e_bc = 0; e_mc = 0;
        end else if (valid && kind != 0) begin
            if (kind == 2) begin
                taken = (op == JAL) || (op == JALR);
                tgt   = (op == JALR) ? ((alu & ~1) & MASK) : ((pc + imm) & MASK);
            end else begin
                case (f3)
                    0, 4:    taken = (alu & 1) == 1;
                    1, 5:    taken = (alu & 1) == 0;
                    default: taken = 0;
                endcase
                tgt = (pc + imm) & MASK;
            end
            mis = (taken != pt) || (taken && pt && tgt != ptg);
            if (e_bc < SMAX) e_bc++;
            if (mis) begin
                if (e_mc < SMAX) e_mc++;
                e_rpc = taken ? tgt : ((pc + 4) & MASK);
            end
            s   = slot_of(pc);
            hit = m[s].v && (m[s].owner == block_of(pc));
            if (kind == 2) begin
                if (op == JAL) m[s] = '{1, block_of(pc), 3, tgt, 1};
            end else if (hit) begin
                m[s].ctr = taken ? ((m[s].ctr < 3) ? m[s].ctr + 1 : 3)
                                 : ((m[s].ctr > 0) ? m[s].ctr - 1 : 0);
                if (taken) m[s].tgt = tgt;
            end else if (taken) begin
                m[s] = '{1, block_of(pc), 2, tgt, 0};
            end
        end
        r = '{mis, e_rpc, e_bc, e_mc};
        reg_q.push_back(r);
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit rst, input int ifpc, input int kind, input bit valid,
                        input int pc, input int f3, input int op, input int imm,
                        input int alu, input bit pt, input int ptg);
        @(posedge clk);
        #1;
        rst_n                = rst;
        bus.if_pc            = ifpc[PC_W-1:0];
        bus.ex_valid         = valid;
        bus.ex_branch        = (kind == 1);
        bus.ex_jump          = (kind == 2);
        bus.ex_pc            = pc[PC_W-1:0];
        bus.ex_funct3        = f3[2:0];
        bus.ex_opcode        = op[6:0];
        bus.ex_imm           = imm;
        bus.ex_alu_result    = alu;
        bus.ex_pred_taken    = pt;
        bus.ex_pred_target   = ptg[PC_W-1:0];
        // lookup sees the table before this cycle's update
        pred_q.push_back(lookup(ifpc));
        model_step(rst, valid, kind, pc, f3, op, imm, alu, pt, ptg & MASK);
    endtask

    task automatic idle(input int ifpc);
        step(1, ifpc, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, got, want);
        end
    endtask

    initial begin
        pexp_t p;
        rexp_t r;
        forever begin
            @(negedge clk);
            if (pred_q.size() > 0) begin
                p = pred_q.pop_front();
                chk("pred_taken", int'(bus.pred_taken), int'(p.t));
                chk("pred_target", int'(bus.pred_target), p.tgt);
            end
            if (reg_q.size() > 0) begin
                r = reg_q.pop_front();
                chk("mispredict", int'(bus.mispredict), int'(r.mis));
                chk("redirect_pc", int'(bus.redirect_pc), r.rpc);
                chk("branch_cnt", int'(bus.branch_cnt), r.bc);
                chk("mispredict_cnt", int'(bus.mispredict_cnt), r.mc);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int    kind, pc, f3, op, imm, alu, ifpc, ptg;
        bit    rst, valid, pt;
        pexp_t pp;
        rexp_t r0;

        rst_n = 1'b0;
        bus.if_pc = '0; bus.ex_valid = 0; bus.ex_branch = 0; bus.ex_jump = 0;
        bus.ex_pc = '0; bus.ex_funct3 = '0; bus.ex_opcode = '0; bus.ex_imm = '0;
        bus.ex_alu_result = '0; bus.ex_pred_taken = 0; bus.ex_pred_target = '0;
        e_rpc = 0; e_bc = 0; e_mc = 0;
        r0 = '{0, 0, 0, 0};
        reg_q.push_back(r0);   // first edge is sampled in reset

        step(0, 'h010, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle('h010);                                          // cold miss
        step(1, 'h010, 1, 1, 'h010, 0, 'h63, 8, 1, 0, 0);     // beq taken, predicted NT
        idle('h010);
        idle('h010);
        step(1, 'h010, 1, 1, 'h010, 0, 'h63, 8, 1, 1, 'h018);
        step(1, 'h010, 1, 1, 'h010, 0, 'h63, 8, 1, 1, 'h018);
        step(1, 'h010, 1, 1, 'h010, 1, 'h63, 8, 1, 1, 'h018); // bne not taken
        step(1, 'h010, 1, 1, 'h010, 1, 'h63, 8, 1, 1, 'h018);
        idle('h010);
        step(1, 'h020, 2, 1, 'h020, 0, JALR, 0, 'h0A5, 0, 0);
        idle('h020);
        idle('h050);                                          // alias of 0x010
        step(1, 'h050, 1, 1, 'h050, 0, 'h63, 'h10, 1, 0, 0);
        idle('h010);
        idle('h050);
        step(0, 'h050, 1, 1, 'h010, 0, 'h63, 8, 1, 0, 0);     // reset beats resolve
        idle('h050);
        step(1, 'h010, 1, 0, 'h010, 0, 'h63, 8, 1, 0, 0);     // ex_valid low
        idle('h010);

        for (int n = 0; n < 1500; n++) begin
            rst   = ($urandom_range(0, 99) != 0);
            kind  = $urandom_range(0, 2);
            valid = ($urandom_range(0, 9) != 0);
            pc    = $urandom_range(0, 47) * 4;
            f3    = $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0, 1:    op = JAL;
                2:       op = JALR;
                default: op = 'h33;
            endcase
            imm   = ($urandom_range(0, 63) - 32) * 2;
            alu   = ($urandom_range(0, 1) != 0) ? int'($urandom) : $urandom_range(0, 600);
            ifpc  = ($urandom_range(0, 3) == 0) ? pc : $urandom_range(0, 47) * 4;
            pp    = lookup(pc);
            if ($urandom_range(0, 3) != 0) begin
                pt  = pp.t;
                ptg = pp.tgt;
            end else begin
                pt  = $urandom_range(0, 1);
                ptg = $urandom_range(0, MASK);
            end
            step(rst, ifpc, kind, valid, pc, f3, op, imm, alu, pt, ptg);
        end

        for (int i = 0; i < 6 && (pred_q.size() > 0 || reg_q.size() > 0); i++) begin
            @(negedge clk);
            #1;
        end
        if (pred_q.size() > 0 || reg_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", pred_q.size() + reg_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised branch resolution and prediction block for the RISC-V pipeline. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters and gives the fetch stage a same-cycle predicted next PC. It resolves branches and jumps in EX using funct3, opcode and the ALU result. On a misprediction it issues a registered redirect/flush, and it keeps performance counters.

Parameters:
PC_W, 9, PC width in bits.
BTB_DEPTH, 16, number of BTB entries; power of two, at least 2. IDX_W = log2(BTB_DEPTH).
CNT_INIT, 2'b10, counter value written on a branch allocation.
STAT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
if_pc  in  PC_W  fetch PC
pred_taken  out  1  prediction for if_pc (combinational)
pred_target  out  PC_W  predicted next PC for if_pc (combinational)
ex_valid  in  1  EX stage holds a valid, non-stalled instruction
ex_pc  in  PC_W  PC of the instruction in EX
ex_branch  in  1  instruction is a conditional branch
ex_jump  in  1  instruction is JAL or JALR
ex_funct3  in  3  branch type
ex_opcode  in  7  JAL = 1101111, JALR = 1100111
ex_imm  in  32  sign-extended immediate
ex_alu_result  in  32  compare result in bit 0, or JALR rs1+imm
ex_pred_taken  in  1  prediction carried down the pipe with this instruction
ex_pred_target  in  PC_W  predicted target carried down the pipe
mispredict  out  1  registered one-cycle flush pulse
redirect_pc  out  PC_W  registered correct next PC
branch_cnt  out  STAT_W  number of resolved branches and jumps
mispredict_cnt  out  STAT_W  number of mispredictions

Behaviour:
- Entry fields: valid, tag = pc[PC_W-1:IDX_W+2], ctr[1:0], target[PC_W-1:0], is_jal. Index = pc[IDX_W+1:2].
- Lookup is combinational. A hit is valid and the tag matches.
  - Hit with (ctr[1] or is_jal): pred_taken = 1, pred_target = target.
  - Otherwise: pred_taken = 0, pred_target = if_pc + 4, truncated to PC_W.
- Resolution (combinational, internal):
  - Branch taken when: funct3 000 and alu[0] = 1; 001 and alu[0] = 0; 100 and alu[0] = 1; 101 and alu[0] = 0. Any other funct3 is not taken.
  - JAL is always taken, target = ex_pc + imm.
  - JALR is always taken, target = {alu[31:1], 0}.
  - A jump with any other opcode counts as not taken.
  - All targets are computed in 32 bits (ex_pc zero-extended), then truncated to PC_W.
  - A resolve event is ex_valid & (ex_branch | ex_jump).
- Misprediction: a resolve event where act_taken != ex_pred_taken, or where both are taken and act_target != ex_pred_target.
- Registered outputs, latency 1:
  - mispredict(t+1) = misprediction(t).
  - redirect_pc(t+1) = act_taken ? act_target : ex_pc + 4.
  - redirect_pc holds its value when there is no misprediction.
- Table update at the clock edge of the resolve event. This is read-before-write: a lookup in the same cycle at the same index sees the old entry.
  - Branch, hit: ctr saturating +1 if taken, -1 if not taken (bounded 0..3). target is overwritten only when taken.
  - Branch, miss, taken: allocate valid = 1, tag, ctr = CNT_INIT, target, is_jal = 0. This replaces any existing entry.
  - Branch, miss, not taken: no change.
  - JAL: allocate or overwrite with ctr = 3, is_jal = 1.
  - JALR: never allocated and never updated. It always mispredicts unless the incoming prediction happens to match.
- Counters:
  - branch_cnt increments on each resolve event.
  - mispredict_cnt increments on each misprediction.
  - Both saturate at all-ones.
- ex_valid = 0: no update, no counting, and mispredict = 0 next cycle.
- Reset (rst_n = 0 at a clock edge) clears all valid bits, ctr, mispredict, redirect_pc and both counters to 0. It overrides any same-cycle resolve event. Reset in the middle of a sequence loses every entry.

Test Plan:
1. After reset, if_pc = 0x010 -> pred_taken = 0, pred_target = 0x014; mispredict = 0; both counters = 0.
2. beq with ex_pc = 0x010, imm = 8, alu = 1, pred_taken = 0 -> next cycle mispredict = 1 for one cycle, redirect_pc = 0x018. Afterwards if_pc = 0x010 -> pred_taken = 1, pred_target = 0x018.
3. Same PC: two further taken updates (ctr saturates at 3), then two not-taken bne-style resolutions -> ctr = 1, lookup pred_taken = 0. branch_cnt = 5.
4. JALR with ex_pc = 0x020, alu = 0x0A5 -> redirect_pc = 0x0A4, mispredict = 1. Lookup of 0x020 still misses.
5. Aliasing at BTB_DEPTH = 16: allocate at 0x010, then lookup 0x050 (same index, different tag) -> pred_taken = 0, pred_target = 0x054. A taken resolve at 0x050 evicts the 0x010 entry.
6. rst_n = 0 in the same cycle as a mispredicting resolve -> next cycle mispredict = 0, all counters 0, previously allocated entries miss. With ex_valid = 0 and ex_branch = 1 -> no update.
